add_round_key_stage: RTL and testbench

//  Inverse-cipher AddRoundKey stage; sits directly upstream of inv_mix_columns.

---
 rtl/aes_pkg.sv | 19 +
 rtl/add_round_key_stage.sv | 111 +++++++++++
 tb/tb_add_round_key_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, AddRoundKey FSM encoding and a column-slice helper.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_NB      = 4;

    typedef enum logic [1:0] {
        ARK_IDLE = 2'b00,
        ARK_LOAD = 2'b01,
        ARK_DONE = 2'b10
    } ark_state_t;

    // Column k of a state: column 0 is the most significant word.
    function automatic logic [AES_WORD_W-1:0] col(input logic [AES_BLOCK_W-1:0] state, input int k);
        return state[AES_BLOCK_W-1-AES_WORD_W*k -: AES_WORD_W];
    endfunction

endpackage

// File: rtl/add_round_key_stage.sv
// Inverse-cipher AddRoundKey stage: latches a state, XORs in four key words, hands off to inv_mix_columns.
// Optional macro ARK_LAST_ROUND_EN adds lastRound/finalValid for the bypass (initial-round) key add.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int WORD_W    = AES_WORD_W,
    parameter int NUM_WORDS = AES_NB
) (
    input  logic                        clock50MHz,
    input  logic                        reset,
    input  logic [WORD_W*NUM_WORDS-1:0] inputData,
    input  logic                        startIn,
    input  logic [WORD_W-1:0]           keyWord,
    input  logic                        keyValid,
    output logic                        keyReady,
    output logic [WORD_W*NUM_WORDS-1:0] outputData,
    output logic                        startTransition,
    output logic                        busy
`ifdef ARK_LAST_ROUND_EN
    ,
    input  logic                        lastRound,
    output logic                        finalValid
`endif
);

    localparam int BLOCK_W = WORD_W * NUM_WORDS;
    localparam int CNT_W   = $clog2(NUM_WORDS);

    ark_state_t         state;
    logic [CNT_W-1:0]   wordCnt;
    logic [BLOCK_W-1:0] work;
    logic [BLOCK_W-1:0] xored;
`ifdef ARK_LAST_ROUND_EN
    logic               last_q;
`endif

    // Working state with the current key word folded into the addressed column.
    always_comb begin
        xored = work;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (wordCnt == k[CNT_W-1:0])
                xored[BLOCK_W-1-WORD_W*k -: WORD_W] = col(work, k) ^ keyWord;
        end
    end

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            state           <= ARK_IDLE;
            wordCnt         <= '0;
            work            <= '0;
            outputData      <= '0;
            keyReady        <= 1'b0;
            startTransition <= 1'b0;
            busy            <= 1'b0;
`ifdef ARK_LAST_ROUND_EN
            last_q          <= 1'b0;
            finalValid      <= 1'b0;
`endif
        end else begin
            case (state)
                ARK_IDLE: begin
                    if (startIn) begin
                        work     <= inputData;
                        wordCnt  <= '0;
                        keyReady <= 1'b1;
                        busy     <= 1'b1;
`ifdef ARK_LAST_ROUND_EN
                        last_q   <= lastRound;
`endif
                        state    <= ARK_LOAD;
                    end
                end
                ARK_LOAD: begin
                    // startIn is deliberately not looked at here; a started job always completes.
                    if (keyValid && keyReady) begin
                        work <= xored;
                        if (wordCnt == CNT_W'(NUM_WORDS-1)) begin
                            wordCnt    <= '0;
                            outputData <= xored;
                            keyReady   <= 1'b0;
`ifdef ARK_LAST_ROUND_EN
                            if (last_q)
                                finalValid <= 1'b1;
                            else
                                startTransition <= 1'b1;
`else
                            startTransition <= 1'b1;
`endif
                            state      <= ARK_DONE;
                        end else begin
                            wordCnt <= wordCnt + 1'b1;
                        end
                    end
                end
                ARK_DONE: begin
                    // Leaving only on startIn low forces a low phase before the next job.
                    if (!startIn) begin
                        startTransition <= 1'b0;
                        busy            <= 1'b0;
`ifdef ARK_LAST_ROUND_EN
                        finalValid      <= 1'b0;
`endif
                        state           <= ARK_IDLE;
                    end
                end
                default: state <= ARK_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage: expected states queued at start, checked when the result appears.
module tb_add_round_key_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] inputData;
    logic         startIn;
    logic [31:0]  keyWord;
    logic         keyValid;
    logic         keyReady;
    logic [127:0] outputData;
    logic         startTransition;
    logic         busy;
`ifdef ARK_LAST_ROUND_EN
    logic         lastRound;
    logic         finalValid;
`else
    logic         finalValid;
    assign finalValid = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] sb[$];
    logic [127:0] last_exp;
    logic         prev_v;

    always #5 clk = ~clk;

    add_round_key_stage dut (
        .clock50MHz      (clk),
        .reset           (rst),
        .inputData       (inputData),
        .startIn         (startIn),
        .keyWord         (keyWord),
        .keyValid        (keyValid),
        .keyReady        (keyReady),
        .outputData      (outputData),
        .startTransition (startTransition),
        .busy            (busy)
`ifdef ARK_LAST_ROUND_EN
        ,
        .lastRound       (lastRound),
        .finalValid      (finalValid)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on each rising result-valid.
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if ((startTransition || finalValid) && !prev_v) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else check("out_data", outputData, sb.pop_front());
            end
            prev_v <= startTransition || finalValid;
        end
    end

    task automatic run_job(input logic [127:0] data, input logic [127:0] key,
                           input logic [127:0] exp, input bit stall, input bit last,
                           input int exp_lat);
        int i, cyc;
        inputData = data;
        startIn   = 1'b1;
`ifdef ARK_LAST_ROUND_EN
        lastRound = last;
`endif
        sb.push_back(exp);
        last_exp = exp;
        @(posedge clk); #1;
        check("kr_after_start", keyReady, 1);
        check("busy_after_start", busy, 1);
        inputData = ~data;
        i = 0; cyc = 0;
        while (i < 4 && cyc < 64) begin
            keyValid = stall ? cyc[0] : 1'b1;
            keyWord  = key[127-32*i -: 32];
            @(posedge clk); #1;
            if (keyValid) i++;
            cyc++;
        end
        keyValid = 1'b0;
        if (i < 4) check("timeout", 1, 0);
        check("latency", cyc, exp_lat);
        check("kr_done", keyReady, 0);
        check("st_done", startTransition, !last);
        check("fv_done", finalValid, last);
`ifdef ARK_LAST_ROUND_EN
        lastRound = 1'b0;
`endif
    endtask

    task automatic release_job();
        startIn = 1'b0;
        @(posedge clk); #1;
        check("st_released", startTransition, 0);
        check("fv_released", finalValid, 0);
        check("busy_released", busy, 0);
    endtask

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] E1 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] D2 = 128'h5f72641557f5bc92f7be3b291db9f91a;

    initial begin
        rst = 1'b1; startIn = 1'b0; keyValid = 1'b0; keyWord = '0; inputData = '0;
        last_exp = '0;
`ifdef ARK_LAST_ROUND_EN
        lastRound = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", outputData, 0);
        check("rst_kr", keyReady, 0);
        check("rst_st", startTransition, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Back-to-back key words.
        run_job(D1, K1, E1, 0, 0, 4);
        release_job();

        // Zero key with keyValid toggling; result equals input.
        run_job(D2, '0, D2, 1, 0, 8);
        release_job();

        // Stalls with a nonzero key: counter must hold across idle cycles.
        run_job(D2, K1, D2 ^ K1, 1, 0, 8);

        // Hold in DONE with keyValid asserted (keyReady low).
        keyValid = 1'b1;
        keyWord  = 32'hdeadbeef;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_st", startTransition, 1);
            check("hold_out", outputData, last_exp);
            check("hold_kr", keyReady, 0);
        end
        keyValid = 1'b0;
        release_job();

        // keyValid in IDLE is ignored.
        keyValid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_kr", keyReady, 0);
            check("idle_busy", busy, 0);
            check("idle_out", outputData, last_exp);
        end
        keyValid = 1'b0;

        // Re-raising startIn begins a fresh job.
        run_job(D1 ^ 128'h1, K1, E1 ^ 128'h1, 0, 0, 4);
        release_job();

        // Reset after two words accepted.
        inputData = D1;
        startIn   = 1'b1;
        @(posedge clk); #1;
        keyValid = 1'b1;
        keyWord  = K1[127:96];
        @(posedge clk); #1;
        keyWord  = K1[95:64];
        @(posedge clk); #1;
        keyValid = 1'b0;
        startIn  = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out", outputData, 0);
        check("arst_kr", keyReady, 0);
        check("arst_st", startTransition, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_kr", keyReady, 0);

        run_job(D1, K1, E1, 0, 0, 4);
        release_job();

`ifdef ARK_LAST_ROUND_EN
        run_job(D1, K1, E1, 0, 1, 4);
        release_job();
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
